// File: rtl/i2c_reg_sequencer.sv
// Runs complete I2C register write/read transactions by driving the I2C master's register bus.
// Optional macro I2C_SEQ_TIMEOUT_EN adds a 16-bit watchdog on interrupt and BUSY waits.
module i2c_reg_sequencer #(
  parameter int         DWIDTH   = 8,
  parameter int         AWIDTH   = 8,
  parameter logic [7:0] PRESCALE = 8'd50
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  input  logic              Rw,
  input  logic [6:0]        DevAddr,
  input  logic [7:0]        RegAddr,
  input  logic [7:0]        WrData,
  output logic              Ready,
  output logic              Done,
  output logic              Err,
  output logic              ArbLost,
  output logic [7:0]        RdData,
  output logic [AWIDTH-1:0] M_Addr,
  output logic [DWIDTH-1:0] M_Wdata,
  input  logic [DWIDTH-1:0] M_Rdata,
  output logic              M_Wr,
  input  logic              M_Int
);

  localparam logic [7:0] ADDR_PRE  = 8'h00;
  localparam logic [7:0] ADDR_CTRL = 8'h01;
  localparam logic [7:0] ADDR_TX   = 8'h02;
  localparam logic [7:0] ADDR_CMD  = 8'h03;
  localparam logic [7:0] CMD_IACK  = 8'h01;
  localparam logic [7:0] CMD_STO   = 8'h40;
  localparam logic [7:0] CTRL_INIT = 8'hC0;

  typedef enum logic [3:0] {
    INIT_PRE, INIT_CTL, IDLE, LOAD_TX, ISSUE, WAIT_INT,
    READ_SR, ACK_INT, FETCH, STOP_ERR, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_inc;
  logic        rw_q, stop_sent_q, err_q, arb_q, ready_q, done_q, wr_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, wd_q, status_q, rd_q, addr_q, wdata_q;
  logic        wr_d, set_err, set_arb, last_phase, final_read, timed_out;
  logic [7:0]  addr_d, wdata_d;

  function automatic logic [7:0] tx_byte(input logic [1:0] ph, input logic rd,
                                         input logic [6:0] dev, input logic [7:0] ra,
                                         input logic [7:0] wd);
    case (ph)
      2'd0:    tx_byte = {dev, 1'b0};
      2'd1:    tx_byte = ra;
      default: tx_byte = rd ? {dev, 1'b1} : wd;
    endcase
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [1:0] ph, input logic rd);
    case (ph)
      2'd0:    cmd_byte = 8'h90;
      2'd1:    cmd_byte = 8'h10;
      2'd2:    cmd_byte = rd ? 8'h90 : 8'h50;
      default: cmd_byte = 8'h68;
    endcase
  endfunction

  assign phase_inc  = phase_q + 2'd1;
  assign last_phase = (phase_q == (rw_q ? 2'd3 : 2'd2));
  // The master itself NACKs the last read byte, so RxNACK is expected there.
  assign final_read = rw_q && (phase_q == 2'd3);

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [15:0] timer_q;
  assign timed_out = (timer_q == 16'hFFFF);
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      timer_q <= '0;
    else if (state_d != state_q)
      timer_q <= '0;
    else if (state_q == WAIT_INT || state_q == STOP_ERR)
      timer_q <= timer_q + 16'd1;
  end
`else
  assign timed_out = 1'b0;
`endif

  // Bus outputs are registered from the transition, so each write lands in its own state's cycle.
  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    addr_d  = 8'h00;
    wdata_d = 8'h00;
    set_err = 1'b0;
    set_arb = 1'b0;
    unique case (state_q)
      INIT_PRE: begin state_d = INIT_CTL; wr_d = 1'b1; addr_d = ADDR_PRE;  wdata_d = PRESCALE;  end
      INIT_CTL: begin state_d = IDLE;     wr_d = 1'b1; addr_d = ADDR_CTRL; wdata_d = CTRL_INIT; end
      IDLE: if (Req) begin
        state_d = LOAD_TX; wr_d = 1'b1; addr_d = ADDR_TX; wdata_d = {DevAddr, 1'b0};
      end
      LOAD_TX: begin
        state_d = ISSUE; wr_d = 1'b1; addr_d = ADDR_CMD; wdata_d = cmd_byte(phase_q, rw_q);
      end
      ISSUE: state_d = WAIT_INT;
      WAIT_INT: begin
        if (M_Int) begin
          state_d = READ_SR; addr_d = ADDR_CMD;
        end else if (timed_out) begin
          state_d = FINISH; wr_d = 1'b1; addr_d = ADDR_CMD; wdata_d = CMD_STO; set_err = 1'b1;
        end
      end
      READ_SR: begin state_d = ACK_INT; wr_d = 1'b1; addr_d = ADDR_CMD; wdata_d = CMD_IACK; end
      ACK_INT: begin
        if (status_q[5]) begin
          state_d = FINISH; set_err = 1'b1; set_arb = 1'b1;
        end else if (status_q[7] && !final_read) begin
          state_d = STOP_ERR; wr_d = 1'b1; addr_d = ADDR_CMD; wdata_d = CMD_STO; set_err = 1'b1;
        end else if (last_phase) begin
          if (rw_q) begin state_d = FETCH; addr_d = ADDR_TX; end
          else      state_d = FINISH;
        end else if (rw_q && phase_inc == 2'd3) begin
          state_d = ISSUE; wr_d = 1'b1; addr_d = ADDR_CMD; wdata_d = cmd_byte(phase_inc, rw_q);
        end else begin
          state_d = LOAD_TX; wr_d = 1'b1; addr_d = ADDR_TX;
          wdata_d = tx_byte(phase_inc, rw_q, dev_q, reg_q, wd_q);
        end
      end
      FETCH: state_d = FINISH;
      STOP_ERR: begin
        addr_d = ADDR_CMD;
        if (stop_sent_q && !M_Rdata[6]) begin
          state_d = FINISH; addr_d = 8'h00;
        end else if (timed_out) begin
          state_d = FINISH; wr_d = 1'b1; wdata_d = CMD_STO;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = INIT_PRE;
    endcase
  end

  // Request latching, phase stepping and status/read-data capture.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= INIT_PRE;
      phase_q     <= 2'd0;
      rw_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      wd_q        <= 8'd0;
      status_q    <= 8'd0;
      stop_sent_q <= 1'b0;
      err_q       <= 1'b0;
      arb_q       <= 1'b0;
      rd_q        <= 8'd0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      wr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= (state_d == IDLE);
      done_q      <= (state_d == FINISH);
      stop_sent_q <= (state_q == STOP_ERR);
      if (state_q == IDLE && Req) begin
        rw_q    <= Rw;
        dev_q   <= DevAddr;
        reg_q   <= RegAddr;
        wd_q    <= WrData;
        phase_q <= 2'd0;
        err_q   <= 1'b0;
        arb_q   <= 1'b0;
      end else if (state_q == ACK_INT && (state_d == LOAD_TX || state_d == ISSUE)) begin
        phase_q <= phase_inc;
      end
      if (set_err) err_q <= 1'b1;
      if (set_arb) arb_q <= 1'b1;
      if (state_q == READ_SR) status_q <= M_Rdata[7:0];
      if (state_q == FETCH)   rd_q     <= M_Rdata[7:0];
    end
  end

  assign Ready   = ready_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign ArbLost = arb_q;
  assign RdData  = rd_q;
  assign M_Wr    = wr_q;
  assign M_Addr  = AWIDTH'(addr_q);
  assign M_Wdata = DWIDTH'(wdata_q);

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Randomized bench for i2c_reg_sequencer: a behavioural I2C master register model plus
// a transaction-level reference that predicts the full register write sequence.
module tb_i2c_reg_sequencer;

  logic       Clk = 1'b0, Rst_n = 1'b0, Req = 1'b0, Rw = 1'b0;
  logic [6:0] DevAddr = 7'd0;
  logic [7:0] RegAddr = 8'd0, WrData = 8'd0;
  logic       Ready, Done, Err, ArbLost, M_Wr;
  logic [7:0] RdData, M_Addr, M_Wdata, M_Rdata;
  logic       M_Int = 1'b0;

  always #5 Clk = ~Clk;

  i2c_reg_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Rw(Rw), .DevAddr(DevAddr), .RegAddr(RegAddr),
    .WrData(WrData), .Ready(Ready), .Done(Done), .Err(Err), .ArbLost(ArbLost),
    .RdData(RdData), .M_Addr(M_Addr), .M_Wdata(M_Wdata), .M_Rdata(M_Rdata),
    .M_Wr(M_Wr), .M_Int(M_Int)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Master register model state
  logic [7:0]  status_reg = 8'h00, rx_reg = 8'h00;
  logic [7:0]  plan [4];
  logic [15:0] wr_log [$];
  logic [15:0] exp_log [$];
  int  phase_idx = 0, pend_phase = 0, int_cnt = -1, busy_cnt = 0;
  int  int_rise = 0, last_delay = 0, first_wr_cyc = -1, done_cnt = 0, exp_done = 0;
  bit  hold_int = 1'b0;
  logic [7:0] exp_rd = 8'h00;

  assign M_Rdata = (M_Addr == 8'h03) ? status_reg : (M_Addr == 8'h02) ? rx_reg : 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural master: logs writes, raises interrupts after commands, models BUSY after STOP.
  always @(negedge Clk) begin
    if (!Rst_n) begin
      M_Int = 1'b0; status_reg = 8'h00; int_cnt = -1; busy_cnt = 0;
    end else begin
      if (Done) done_cnt++;
      if (M_Wr) begin
        wr_log.push_back({M_Addr, M_Wdata});
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        if (M_Addr == 8'h03) begin
          if (M_Wdata == 8'h01) begin
            checkOutput("int_to_iack", cyc - int_rise, (last_delay == 0) ? 3 : 2);
            M_Int = 1'b0; status_reg[0] = 1'b0;
          end else if (M_Wdata == 8'h40) begin
            busy_cnt = $urandom_range(1, 5);
          end else if (M_Wdata[7] | M_Wdata[5] | M_Wdata[4]) begin
            pend_phase = phase_idx;
            phase_idx++;
            if (!hold_int) begin
              last_delay = $urandom_range(0, 4);
              int_cnt = last_delay;
            end
          end
        end
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) status_reg[6] = 1'b0;
      end
      if (int_cnt == 0) begin
        M_Int = 1'b1; status_reg = plan[pend_phase & 3] | 8'h41; int_rise = cyc; int_cnt = -1;
      end else if (int_cnt > 0) begin
        int_cnt--;
      end
    end
  end

  task automatic checkLog(input string tag);
    checkOutput({tag, "_len"}, wr_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
      checkOutput($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_log[i]);
  endtask

  task automatic resetAndInit();
    int rel, rdy;
    Rst_n = 1'b0; Req = 1'b0;
    #1;
    checkOutput("rst_ready", Ready, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_err_arb", {Err, ArbLost}, 0);
    checkOutput("rst_rddata", RdData, 0);
    checkOutput("rst_bus", {M_Wr, M_Addr, M_Wdata}, 0);
    exp_rd = 8'h00;
    repeat (2) begin @(negedge Clk); #1; end
    wr_log.delete();
    Rst_n = 1'b1; rel = cyc; rdy = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk); #1;
      if (Ready) begin rdy = cyc; break; end
    end
    checkOutput("ready_latency", rdy - rel, 2);
    exp_log.delete();
    exp_log.push_back(16'h0032);
    exp_log.push_back(16'h01C0);
    checkLog("init");
  endtask

  // One full transaction; kind 0 = all ACK, 1 = RxNACK at fail_ph, 2 = arbitration loss at fail_ph.
  task automatic applyStimulus(input bit rw, input logic [6:0] dev, input logic [7:0] ra,
                               input logic [7:0] wd, input logic [7:0] rx, input int kind,
                               input int fail_ph, input bit poke_busy);
    logic [7:0] tx [4];
    logic [7:0] cmd [4];
    bit exp_err, exp_arb, got, ok;
    int acc_cyc, n;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (Ready) begin ok = 1'b1; break; end
      @(negedge Clk); #1;
    end
    if (!ok) checkOutput("ready_wait", 0, 1);
    for (int p = 0; p < 4; p++) plan[p] = 8'h00;
    if (kind == 1) plan[fail_ph] = 8'h80;
    if (kind == 2) plan[fail_ph] = 8'h20;
    tx[0] = {dev, 1'b0}; tx[1] = ra; tx[2] = rw ? {dev, 1'b1} : wd; tx[3] = 8'h00;
    cmd[0] = 8'h90; cmd[1] = 8'h10; cmd[2] = rw ? 8'h90 : 8'h50; cmd[3] = 8'h68;
    exp_log.delete(); exp_err = 1'b0; exp_arb = 1'b0;
    for (int p = 0; p < (rw ? 4 : 3); p++) begin
      if (!(rw && p == 3)) exp_log.push_back({8'h02, tx[p]});
      exp_log.push_back({8'h03, cmd[p]});
      exp_log.push_back(16'h0301);
      if (plan[p][5]) begin exp_err = 1'b1; exp_arb = 1'b1; break; end
      if (plan[p][7] && !(rw && p == 3)) begin
        exp_log.push_back(16'h0340); exp_err = 1'b1; break;
      end
    end
    if (rw && !exp_err) exp_rd = rx;
    rx_reg = rx; phase_idx = 0;
    Rw = rw; DevAddr = dev; RegAddr = ra; WrData = wd; Req = 1'b1;
    acc_cyc = cyc; wr_log.delete(); first_wr_cyc = -1;
    @(negedge Clk); #1;
    Req = 1'b0;
    if (poke_busy) begin
      repeat (3) begin @(negedge Clk); #1; end
      Rw = ~rw; DevAddr = ~dev; RegAddr = ~ra; WrData = ~wd; Req = 1'b1;
      @(negedge Clk); #1;
      Req = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (Done) begin got = 1'b1; break; end
      @(negedge Clk); #1;
    end
    checkOutput("done_seen", got, 1);
    if (got) begin
      exp_done++;
      checkOutput("err", Err, exp_err);
      checkOutput("arblost", ArbLost, exp_arb);
      checkOutput("rddata", RdData, exp_rd);
      if (kind == 1 && exp_err) checkOutput("busy_clear_at_done", status_reg[6], 0);
      checkOutput("acc_to_wr", first_wr_cyc - acc_cyc, 1);
      checkLog(rw ? "rd" : "wr");
      Req = 1'b1; Rw = ~rw;
      @(negedge Clk); #1;
      Req = 1'b0;
      checkOutput("ready_after_done", Ready, 1);
      n = wr_log.size();
      repeat (2) begin @(negedge Clk); #1; end
      checkOutput("req_in_done_ignored", {Ready, 8'(wr_log.size() - n)}, {1'b1, 8'd0});
    end
  endtask

  initial begin
    int rw, r, kind;
    @(negedge Clk); #1;
    resetAndInit();
    applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 0, 1'b0);
    applyStimulus(1'b1, 7'h50, 8'h10, 8'h00, 8'h3C, 0, 0, 1'b0);
    applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 0, 1'b0);
    applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 2, 1, 1'b0);
    applyStimulus(1'b1, 7'h22, 8'h33, 8'h00, 8'h5A, 1, 3, 1'b1);
    for (int t = 0; t < 20; t++) begin
      rw = $urandom_range(0, 1);
      r = $urandom_range(0, 3);
      kind = (r < 2) ? 0 : (r == 2) ? 1 : 2;
      applyStimulus(rw[0], 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    kind, $urandom_range(0, rw ? 3 : 2), 1'($urandom));
    end
    // Abort mid-transaction: interrupt withheld so the sequencer parks in WAIT_INT.
    hold_int = 1'b1;
    for (int i = 0; i < 50 && !Ready; i++) begin @(negedge Clk); #1; end
    Rw = 1'b0; DevAddr = 7'h11; RegAddr = 8'h22; WrData = 8'h33; Req = 1'b1;
    @(negedge Clk); #1;
    Req = 1'b0;
    repeat (8) begin @(negedge Clk); #1; end
    checkOutput("parked_busy", {Ready, M_Int}, 0);
    hold_int = 1'b0;
    resetAndInit();
    repeat (5) begin @(negedge Clk); #1; end
    checkOutput("done_count", done_cnt, exp_done);
    applyStimulus(1'b1, 7'h50, 8'h10, 8'h00, 8'hC3, 0, 0, 1'b0);
    checkOutput("done_count_final", done_cnt, exp_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
